// File: rtl/reg_dump.sv
// -----------------------------------------------------------------------------
// reg_dump -- sequential reader for the register file.
//
// On a start pulse the block walks register indices in ascending order,
// driving the shared read-address port, and streams every captured value,
// tagged with its index, over a valid/ready interface toward a debug or
// trace sink. It never writes the register file. The datapath must not use
// the shared read port while busy is high.
//
// Configuration macro:
//   REG_DUMP_SKIP_ZERO_EN  when defined, the walk starts at index 1 because
//                          register 0 is hardwired zero. When undefined, the
//                          walk starts at index 0.
//
// Parameters:
//   NUM_REGS  number of registers walked (indices 0..NUM_REGS-1)
//   ADDR_W    register index width
//   DATA_W    register data width
//
// Ports:
//   clk           in   clock, all state on the rising edge
//   rst           in   asynchronous active-high reset
//   start         in   begin a dump (sampled only while idle)
//   busy          out  high while a dump is in progress
//   done          out  one-cycle pulse after the last beat is accepted
//   rf_read_reg   out  read address to the register file
//   rf_read_data  in   combinational read data from the register file
//   out_valid     out  beat valid
//   out_ready     in   sink accepts the beat
//   out_index     out  register index of the current beat
//   out_data      out  register value of the current beat
// -----------------------------------------------------------------------------
module reg_dump #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_read_reg,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_data
);

`ifdef REG_DUMP_SKIP_ZERO_EN
    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);
`else
    localparam logic [ADDR_W-1:0] FIRST = '0;
`endif
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              accept;

    // ptr always points at the register to be captured on the next accept,
    // so the combinational read data is already settled when that edge comes.
    assign rf_read_reg = ptr;
    assign accept      = out_valid & out_ready;

    assign busy = (state == SEND);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= FIRST;
            out_valid <= 1'b0;
            out_index <= '0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        out_data  <= rf_read_data;
                        out_index <= FIRST;
                        out_valid <= 1'b1;
                        ptr       <= FIRST + ADDR_W'(1);
                        state     <= SEND;
                    end
                end

                SEND: begin
                    // Without an accept everything holds, so the beat stays
                    // stable for the sink and start is ignored throughout.
                    if (accept) begin
                        if (out_index != LAST) begin
                            out_data  <= rf_read_data;
                            out_index <= ptr;
                            // After the final capture this wraps past the
                            // last index; that address is never consumed.
                            ptr       <= ptr + ADDR_W'(1);
                        end else begin
                            out_valid <= 1'b0;
                            ptr       <= FIRST;
                            state     <= DONE;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
